// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and
// the oversampling factor used by the bit timing.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int OVS = 16;

endpackage

// File: rtl/uart_tx_fifo_baud_gen.sv
// Mod-DVSR oversample tick generator; clr realigns the tick phase to a frame
// start so every bit boundary lands an exact multiple of DVSR after the pop.
module baud_gen #(
  parameter int DVSR = 163
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick
);

  localparam int CW = $clog2(DVSR);

  logic [CW-1:0] cnt_r;

  // Free-running divider, restarted whenever a frame begins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == CW'(DVSR - 1)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign s_tick = (cnt_r == CW'(DVSR - 1));

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a show-ahead FIFO: pops a word whenever the line
// is free and sends start, DBIT data bits LSB first, then the stop period.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SW = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  state_t          state_r, state_s;
  logic [SW-1:0]   s_cnt_r, s_cnt_s;
  logic [NW-1:0]   n_cnt_r, n_cnt_s;
  logic [DBIT-1:0] b_reg_r, b_reg_s;
  logic            tx_r, tx_s;
  logic            rd_s, done_s, s_tick;

  baud_gen #(.DVSR(DVSR)) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (rd_s),
    .s_tick(s_tick)
  );

  // Next-state, datapath updates and pop/done strobes
  always_comb begin
    state_s = state_r;
    s_cnt_s = s_cnt_r;
    n_cnt_s = n_cnt_r;
    b_reg_s = b_reg_r;
    rd_s    = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty) begin
          rd_s    = 1'b1;
          b_reg_s = r_data;
          s_cnt_s = '0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (s_tick && (s_cnt_r == SW'(OVS - 1))) begin
          s_cnt_s = '0;
          n_cnt_s = '0;
          state_s = DATA;
        end else if (s_tick) begin
          s_cnt_s = s_cnt_r + SW'(1);
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      DATA: begin
        if (s_tick && (s_cnt_r == SW'(OVS - 1))) begin
          s_cnt_s = '0;
          b_reg_s = b_reg_r >> 1;
          if (n_cnt_r == NW'(DBIT - 1)) begin
            state_s = STOP;
          end else begin
            n_cnt_s = n_cnt_r + NW'(1);
          end
        end else if (s_tick) begin
          s_cnt_s = s_cnt_r + SW'(1);
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      STOP: begin
        if (s_tick && (s_cnt_r == SW'(SB_TICK - 1))) begin
          done_s = 1'b1;
          // Chain straight into the next frame when data is already waiting
          if (!empty) begin
            rd_s    = 1'b1;
            b_reg_s = r_data;
            s_cnt_s = '0;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else if (s_tick) begin
          s_cnt_s = s_cnt_r + SW'(1);
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered, so tx moves on the same edge
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = b_reg_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      s_cnt_r <= '0;
      n_cnt_r <= '0;
      b_reg_r <= '0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      s_cnt_r <= s_cnt_s;
      n_cnt_r <= n_cnt_s;
      b_reg_r <= b_reg_s;
      tx_r    <= tx_s;
    end
  end

  // Strobes are gated so nothing leaks out while reset holds the FSM in IDLE
  assign rd           = rd_s & reset;
  assign tx_done_tick = done_s & reset;
  assign tx           = tx_r;
  assign tx_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench: a FIFO model feeds the transmitter and a
// monitor decodes the serial line cycle by cycle against the queued bytes.
module tb_uart_tx_fifo;

  localparam int BITC    = 32;
  localparam int FRAME   = 10 * BITC;
  localparam int FRAME32 = 9 * BITC + 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, empty, rd, tx, tx_busy, tx_done_tick;
  logic [7:0] r_data;
  logic       empty2, rd2, tx2, tx_busy2, done2;
  logic [7:0] r_data2;

  int tests = 0;
  int fails = 0;

  logic [7:0] wr_mem [0:255];
  int         wr_cnt = 0;
  int         head = 0;
  logic [7:0] exp_q [$];

  int         rd_pulses = 0;
  int         frames_done = 0;
  int         b2b = 0;
  int         mon_cyc = 0;
  bit         mon_active = 1'b0;
  logic [7:0] cur = 8'h00;

  uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .DVSR(2)) dut (
    .clk(clk), .reset(reset), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  uart_tx_fifo #(.DBIT(8), .SB_TICK(32), .DVSR(2)) dut32 (
    .clk(clk), .reset(reset), .empty(empty2), .r_data(r_data2),
    .rd(rd2), .tx(tx2), .tx_busy(tx_busy2), .tx_done_tick(done2)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_mem[wr_cnt[7:0]] = b;
    wr_cnt++;
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_timeout", int'(frames_done >= n), 1);
  endtask

  // FIFO model: pops on a seen rd, shows garbage on r_data while empty
  initial begin
    logic rd_seen, empty_seen;
    empty  = 1'b1;
    r_data = 8'h00;
    forever begin
      @(negedge clk);
      rd_seen    = rd;
      empty_seen = empty;
      @(posedge clk);
      #1;
      if (rd_seen) begin
        check("rd_while_empty", int'(empty_seen), 0);
        if (!empty_seen) head++;
      end
      empty  = (head == wr_cnt);
      r_data = empty ? 8'($urandom) : wr_mem[head[7:0]];
    end
  end

  // Monitor: compares every line cycle against the byte popped on rd
  always @(negedge clk) begin
    int  slot, e;
    bit  ended;
    if (!reset) begin
      mon_active = 1'b0;
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(tx_busy), 0);
      check("reset_rd", int'(rd), 0);
    end else begin
      ended = 1'b0;
      if (mon_active) begin
        mon_cyc++;
        slot = (mon_cyc - 1) / BITC;
        if (slot == 0) e = 0;
        else if (slot <= 8) e = int'(cur[slot-1]);
        else e = 1;
        check("tx_bit", int'(tx), e);
        check("busy_frame", int'(tx_busy), 1);
        check("done_tick", int'(tx_done_tick), int'(mon_cyc == FRAME));
        if (mon_cyc == FRAME) begin
          mon_active = 1'b0;
          frames_done++;
          ended = 1'b1;
        end else begin
          check("rd_mid_frame", int'(rd), 0);
        end
      end else begin
        check("idle_tx", int'(tx), 1);
        check("idle_busy", int'(tx_busy), 0);
        check("idle_done", int'(tx_done_tick), 0);
      end
      if (rd) begin
        rd_pulses++;
        check("rd_has_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        if (ended) b2b++;
        mon_active = 1'b1;
        mon_cyc = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    reset   = 1'b0;
    empty2  = 1'b1;
    r_data2 = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx", int'(tx), 1);
    check("rst_rd", int'(rd), 0);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_done", int'(tx_done_tick), 0);
    check("rst_tx32", int'(tx2), 1);
    @(posedge clk);
    #2 reset = 1'b1;

    // Empty FIFO: no pops, line idle
    repeat (1000) @(negedge clk);
    check("idle_rd_count", rd_pulses, 0);

    // Single byte
    @(negedge clk);
    push(8'hA5);
    wait_frames(1, 1000);
    check("a5_rd_count", rd_pulses, 1);
    repeat (3) @(negedge clk);
    check("a5_fifo_empty", int'(empty), 1);

    // Three queued bytes go out back to back
    base = b2b;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    wait_frames(4, 2000);
    check("burst_rd_count", rd_pulses, 4);
    check("burst_b2b", b2b - base, 2);

    // Write during a frame in flight
    repeat (5) @(negedge clk);
    base = b2b;
    push(8'h55);
    k = 0;
    while (!(mon_active && mon_cyc >= 100) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("inflight_reached", int'(mon_active && mon_cyc >= 100), 1);
    push(8'h3C);
    wait_frames(6, 2000);
    check("inflight_b2b", b2b - base, 1);
    check("inflight_rd_count", rd_pulses, 6);

    // Random bytes with random gaps
    base = frames_done;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      push(8'($urandom));
    end
    wait_frames(base + 6, 3000);
    check("rand_rd_count", rd_pulses, 12);

    // Asynchronous reset in the middle of the data bits
    @(negedge clk);
    push(8'hC3);
    k = 0;
    while (!(mon_active && mon_cyc >= 100) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("midreset_reached", int'(mon_active && mon_cyc >= 100), 1);
    check("midreset_pre_tx", int'(tx), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_tx", int'(tx), 1);
    check("async_rd", int'(rd), 0);
    check("async_busy", int'(tx_busy), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (60) @(negedge clk);
    check("post_reset_rd_count", rd_pulses, 13);
    check("post_reset_empty", int'(empty), 1);

    // Two stop bits on the second instance
    @(negedge clk);
    empty2  = 1'b0;
    r_data2 = 8'h00;
    #1;
    check("sb32_rd", int'(rd2), 1);
    @(posedge clk);
    #1;
    empty2  = 1'b1;
    r_data2 = 8'hFF;
    for (int c = 1; c <= FRAME32; c++) begin
      @(negedge clk);
      check("sb32_tx", int'(tx2), int'(c > 9 * BITC));
      check("sb32_done", int'(done2), int'(c == FRAME32));
      check("sb32_busy", int'(tx_busy2), 1);
      check("sb32_rd_idle", int'(rd2), 0);
    end
    @(negedge clk);
    check("sb32_end_tx", int'(tx2), 1);
    check("sb32_end_busy", int'(tx_busy2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
